// File: rtl/regfile_32x32.sv
// regfile_32x32 -- RV32I integer register file for the single-cycle core.
//
// Two combinational read ports supply the rs1/rs2 operands to the ALU and adder.
// One synchronous write port accepts the writeback result. The storage array has
// no reset, so it can map onto distributed RAM. After reset, an INIT sweep writes
// zero into x1..x31. rdy_o rises when the sweep is complete. x0 always reads 0.
//
// Optional macro: REGFILE_BYPASS_EN
//   When defined, a write in RUN is forwarded to a read port that addresses the
//   same non-zero register in the same cycle.
//   When undefined, a same-cycle read returns the array contents from before the
//   write.
//
// Ports:
//   clk_i       core clock; all state updates happen on the rising edge
//   rst_i       synchronous, active-high reset
//   rs1_addr_i  read port 1 address
//   rs2_addr_i  read port 2 address
//   rs1_data_o  read port 1 data (combinational)
//   rs2_data_o  read port 2 data (combinational)
//   rd_wren_i   writeback write enable
//   rd_addr_i   writeback address
//   rd_data_i   writeback data
//   rdy_o       high once the init sweep has finished

module regfile_32x32 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              rd_wren_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              rdy_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_run;

  assign w_run = (r_state == ST_RUN);
  assign rdy_o = w_run;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and array write-port steering
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = rd_addr_i;
    w_wdata     = rd_data_i;
    if (!rst_i) begin
      unique case (r_state)
        ST_INIT: begin
          // The sweep owns the write port; rd_wren_i is ignored in INIT.
          w_we    = 1'b1;
          w_waddr = r_cnt;
          w_wdata = '0;
          if (r_cnt == '1) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          w_we = rd_wren_i && (rd_addr_i != '0);
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  // The sweep starts at 1: x0 is never stored because its reads are forced to 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= ADDR_W'(1);
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  // Storage array without a reset, so it can be implemented as distributed RAM.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  logic [DATA_W-1:0] w_rs1_arr;
  logic [DATA_W-1:0] w_rs2_arr;

  assign w_rs1_arr = r_mem[rs1_addr_i];
  assign w_rs2_arr = r_mem[rs2_addr_i];

`ifdef REGFILE_BYPASS_EN
  logic w_fwd_rs1;
  logic w_fwd_rs2;

  assign w_fwd_rs1 = rd_wren_i && (rd_addr_i == rs1_addr_i);
  assign w_fwd_rs2 = rd_wren_i && (rd_addr_i == rs2_addr_i);

  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (w_run && (rs1_addr_i != '0)) begin
      rs1_data_o = w_fwd_rs1 ? rd_data_i : w_rs1_arr;
    end
    if (w_run && (rs2_addr_i != '0)) begin
      rs2_data_o = w_fwd_rs2 ? rd_data_i : w_rs2_arr;
    end
  end
`else
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (w_run && (rs1_addr_i != '0)) begin
      rs1_data_o = w_rs1_arr;
    end
    if (w_run && (rs2_addr_i != '0)) begin
      rs2_data_o = w_rs2_arr;
    end
  end
`endif

endmodule
